instr_fetch_queue: RTL and testbench
====================================

# instr_fetch_queue

Decoupling FIFO between the Fetch stage and the Decode stage of the out-of-order core. It buffers fetched instruction words with their PCs, so fetch keeps streaming while Decode/Rename stalls on RS, ROB or LSQ back-pressure. Decode consumes entries through a valid/ready handshake. A flush empties the queue in one cycle.

## Interface
- DEPTH, 8, number of entries; power of two, 2..64.
- PTR_W, 3, log2(DEPTH).
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high; clears all state on the next rising edge.
- flush  input  1  synchronous discard of all entries; same effect as reset on queue state.
- enq_valid  input  1  Fetch presents an instruction this cycle.
- enq_instr  input  32  instruction word, already byte-swapped to little-endian order.
- enq_pc  input  32  PC of enq_instr.
- enq_ready  output  1  queue can accept; equals (count != DEPTH).
- deq_valid  output  1  head entry present; equals (count != 0).
- deq_instr  output  32  head instruction word; 32'h0 when empty.
- deq_pc  output  32  head PC; 32'h0 when empty.
- deq_ready  input  1  Decode accepts the head entry this cycle.
- count  output  PTR_W+1  current occupancy, 0..DEPTH.

## Operation
- Storage: DEPTH x 64-bit register array {pc, instr}, head pointer, tail pointer (PTR_W bits each), and a count register (PTR_W+1 bits).
- Enqueue fires when enq_valid && enq_ready. It writes the array at tail, and tail increments modulo DEPTH.
- Dequeue fires when deq_valid && deq_ready. Head increments modulo DEPTH.
- Count update:
  - count+1 on enqueue only.
  - count-1 on dequeue only.
  - unchanged when both fire or neither fires.
- Pointer wrap: DEPTH-1 -> 0. No separate full/empty flag; count alone distinguishes them.
- Both handshake outputs depend only on registered count. There is no combinational path from deq_ready to enq_ready or from enq_valid to deq_valid.
- Full queue: enq_ready=0 even if a dequeue fires in the same cycle. Fetch must hold enq_instr/enq_pc stable until accepted.
- Empty queue: deq_valid=0. An enqueue in that cycle does not bypass to the outputs.
- deq_instr/deq_pc are a read of array[head] gated by deq_valid. They must be 0 whenever count==0.
- Priority, highest first: reset, then flush, then enqueue/dequeue. On flush, any enqueue or dequeue handshake in that cycle is discarded.
- Array contents are not cleared by reset or flush; only pointers and count are cleared.

## Timing
- Reset values, one edge after reset=1:
  - head=0, tail=0, count=0.
  - enq_ready=1, deq_valid=0, deq_instr=0, deq_pc=0.
- Enqueue-to-dequeue latency is 1 cycle: an entry accepted at edge N is presented on deq_* after edge N and can be consumed at edge N+1.
- Sustained throughput is 1 enqueue and 1 dequeue per cycle whenever 0 < count < DEPTH.
- A reset or flush asserted mid-stream takes effect at the next edge. Entries present before that edge are lost, including one accepted in the same cycle.
- Flush deasserted at cycle N: an enqueue in cycle N+1 is accepted normally.

## Test plan
- Reset/fill:
  - Stimulus: reset 2 cycles, then enqueue 8 words 0x00000013+k with pc=4k and deq_ready=0.
  - Required: count 1..8; enq_ready drops to 0 after the 8th edge; deq_instr=0x00000013, deq_pc=0 throughout.
- Drain order:
  - Stimulus: from full, deq_ready=1 for 8 cycles.
  - Required: deq_pc sequence 0,4,...,28; count reaches 0; deq_valid=0 and deq_instr=0 after the last edge.
- Full plus simultaneous dequeue:
  - Stimulus: from full, enq_valid=1 and deq_ready=1 in the same cycle.
  - Required: only the dequeue fires; count=7; the held word is accepted next cycle and count returns to 8.
- Wrap-around streaming:
  - Stimulus: 20 consecutive words enqueued while deq_ready=1 every cycle after the first.
  - Required: count stays 1; outputs follow inputs with 1-cycle delay; pointers wrap twice with no loss or duplication.
- Flush priority:
  - Stimulus: with count=5, assert flush together with enq_valid and deq_ready.
  - Required: next cycle count=0 and deq_valid=0; the following enqueue of 0x00A00093 appears at the head with count=1.
- Reset mid-operation:
  - Stimulus: with count=3, assert reset for 1 cycle.
  - Required: all outputs return to their reset values; a subsequent 3 enqueues/3 dequeues reproduce the exact input order.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// -----------------------------------------------------------------------------
// instr_fetch_queue
//
// Decoupling FIFO between Fetch and Decode. It holds fetched instruction words
// together with their PCs, so Fetch can keep streaming while Decode/Rename is
// stalled by back-pressure. Decode drains entries through a valid/ready
// handshake. A flush discards every entry in one cycle.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous active-high reset; clears pointers and occupancy
//   flush      synchronous discard of all entries; same queue effect as reset
//   enq_valid  Fetch presents {enq_pc, enq_instr} this cycle
//   enq_instr  instruction word (little-endian order)
//   enq_pc     PC of enq_instr
//   enq_ready  queue can accept (count != DEPTH)
//   deq_valid  head entry present (count != 0)
//   deq_instr  head instruction word, 0 when empty
//   deq_pc     head PC, 0 when empty
//   deq_ready  Decode accepts the head entry this cycle
//   count      current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module instr_fetch_queue #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             enq_valid,
    input  logic [31:0]      enq_instr,
    input  logic [31:0]      enq_pc,
    output logic             enq_ready,
    output logic             deq_valid,
    output logic [31:0]      deq_instr,
    output logic [31:0]      deq_pc,
    input  logic             deq_ready,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    // Entry layout: {pc, instr}. Contents are never cleared; only the
    // pointers and occupancy decide what is valid.
    logic [63:0]      mem_reg [DEPTH];

    logic [PTR_W-1:0] head_reg;
    logic [PTR_W-1:0] head_next;
    logic [PTR_W-1:0] tail_reg;
    logic [PTR_W-1:0] tail_next;
    logic [PTR_W:0]   count_reg;
    logic [PTR_W:0]   count_next;

    logic             enq_fire;
    logic             deq_fire;
    logic [63:0]      head_entry;

    // Handshake outputs come only from the registered occupancy, so there is
    // no combinational path from deq_ready to enq_ready or from enq_valid to
    // deq_valid. A full queue refuses a write even when a read fires.
    assign enq_ready = (count_reg != FULL_COUNT);
    assign deq_valid = (count_reg != '0);
    assign count     = count_reg;

    assign enq_fire  = enq_valid && enq_ready;
    assign deq_fire  = deq_valid && deq_ready;

    // Head read is gated so stale array contents never leak out when empty.
    assign head_entry = mem_reg[head_reg];
    assign deq_instr  = deq_valid ? head_entry[31:0]  : 32'h0;
    assign deq_pc     = deq_valid ? head_entry[63:32] : 32'h0;

    // Pointer arithmetic wraps DEPTH-1 -> 0 naturally because DEPTH is a
    // power of two and the pointers are exactly PTR_W bits wide.
    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (enq_fire) begin
            tail_next = tail_reg + PTR_W'(1);
        end
        if (deq_fire) begin
            head_next = head_reg + PTR_W'(1);
        end
        case ({enq_fire, deq_fire})
            2'b10:   count_next = count_reg + (PTR_W + 1)'(1);
            2'b01:   count_next = count_reg - (PTR_W + 1)'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            // Any handshake in a flush cycle is discarded along with the queue.
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    // Storage write has no reset so it maps onto plain distributed memory.
    // Writing during a flush is harmless: the slot is outside the valid window.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            mem_reg[tail_reg] <= {enq_pc, enq_instr};
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_queue
//
// Directed testbench for instr_fetch_queue. Each scenario task drives its own
// stimulus and compares outputs against hand-computed values. Inputs change
// 1 ns after the rising edge; outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_instr_fetch_queue;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        enq_valid;
    logic [31:0] enq_instr;
    logic [31:0] enq_pc;
    logic        enq_ready;
    logic        deq_valid;
    logic [31:0] deq_instr;
    logic [31:0] deq_pc;
    logic        deq_ready;
    logic [3:0]  count;

    int checks;
    int errors;

    instr_fetch_queue #(
        .DEPTH(8),
        .PTR_W(3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .enq_valid (enq_valid),
        .enq_instr (enq_instr),
        .enq_pc    (enq_pc),
        .enq_ready (enq_ready),
        .deq_valid (deq_valid),
        .deq_instr (deq_instr),
        .deq_pc    (deq_pc),
        .deq_ready (deq_ready),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Stimulus helper only: one accepted enqueue (queue assumed not full).
    task automatic push(input logic [31:0] instr, input logic [31:0] pc);
        enq_valid = 1'b1;
        enq_instr = instr;
        enq_pc    = pc;
        step();
        enq_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        checks += 5;
        if (count !== 4'd0) begin
            errors++; $display("FAIL reset_count: got %0d expected 0", count);
        end
        if (enq_ready !== 1'b1) begin
            errors++; $display("FAIL reset_enq_ready: got %b expected 1", enq_ready);
        end
        if (deq_valid !== 1'b0) begin
            errors++; $display("FAIL reset_deq_valid: got %b expected 0", deq_valid);
        end
        if (deq_instr !== 32'h0) begin
            errors++; $display("FAIL reset_deq_instr: got %h expected 00000000", deq_instr);
        end
        if (deq_pc !== 32'h0) begin
            errors++; $display("FAIL reset_deq_pc: got %h expected 00000000", deq_pc);
        end
        $display("test_reset done: count=%0d enq_ready=%b deq_valid=%b", count, enq_ready, deq_valid);
    endtask

    task automatic test_fill();
        for (int k = 0; k < 8; k++) begin
            push(32'h0000_0013 + 32'(k), 32'(4 * k));
            checks += 4;
            if (count !== 4'(k + 1)) begin
                errors++; $display("FAIL fill_count[%0d]: got %0d expected %0d", k, count, k + 1);
            end
            if (enq_ready !== (k < 7)) begin
                errors++; $display("FAIL fill_enq_ready[%0d]: got %b expected %b", k, enq_ready, (k < 7));
            end
            if (deq_instr !== 32'h0000_0013) begin
                errors++; $display("FAIL fill_deq_instr[%0d]: got %h expected 00000013", k, deq_instr);
            end
            if (deq_pc !== 32'h0) begin
                errors++; $display("FAIL fill_deq_pc[%0d]: got %h expected 00000000", k, deq_pc);
            end
            $display("fill k=%0d count=%0d enq_ready=%b", k, count, enq_ready);
        end
    endtask

    task automatic test_drain();
        deq_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            checks += 2;
            if (deq_pc !== 32'(4 * k)) begin
                errors++; $display("FAIL drain_pc[%0d]: got %h expected %h", k, deq_pc, 32'(4 * k));
            end
            if (deq_instr !== 32'h13 + 32'(k)) begin
                errors++; $display("FAIL drain_instr[%0d]: got %h expected %h", k, deq_instr, 32'h13 + 32'(k));
            end
            step();
            checks++;
            if (count !== 4'(7 - k)) begin
                errors++; $display("FAIL drain_count[%0d]: got %0d expected %0d", k, count, 7 - k);
            end
            $display("drain k=%0d count=%0d", k, count);
        end
        deq_ready = 1'b0;
        checks += 2;
        if (deq_valid !== 1'b0) begin
            errors++; $display("FAIL drain_deq_valid: got %b expected 0", deq_valid);
        end
        if (deq_instr !== 32'h0) begin
            errors++; $display("FAIL drain_deq_instr: got %h expected 00000000", deq_instr);
        end
    endtask

    task automatic test_full_simul();
        for (int k = 0; k < 8; k++) begin
            push(32'h0000_0100 + 32'(k), 32'h0000_1000 + 32'(4 * k));
        end
        enq_valid = 1'b1;
        enq_instr = 32'h0000_0200;
        enq_pc    = 32'h0000_2000;
        deq_ready = 1'b1;
        checks++;
        if (enq_ready !== 1'b0) begin
            errors++; $display("FAIL full_enq_ready: got %b expected 0", enq_ready);
        end
        step();
        deq_ready = 1'b0;
        checks += 2;
        if (count !== 4'd7) begin
            errors++; $display("FAIL full_simul_count: got %0d expected 7", count);
        end
        if (deq_pc !== 32'h0000_1004) begin
            errors++; $display("FAIL full_simul_head: got %h expected 00001004", deq_pc);
        end
        $display("full simul: count=%0d head_pc=%h", count, deq_pc);
        step();
        enq_valid = 1'b0;
        checks++;
        if (count !== 4'd8) begin
            errors++; $display("FAIL full_retry_count: got %0d expected 8", count);
        end
        $display("full retry: count=%0d", count);
        deq_ready = 1'b1;
        for (int k = 1; k < 9; k++) begin
            logic [31:0] exp_pc;
            exp_pc = (k < 8) ? 32'h0000_1000 + 32'(4 * k) : 32'h0000_2000;
            checks++;
            if (deq_pc !== exp_pc) begin
                errors++; $display("FAIL full_drain_pc[%0d]: got %h expected %h", k, deq_pc, exp_pc);
            end
            step();
        end
        deq_ready = 1'b0;
        checks++;
        if (count !== 4'd0) begin
            errors++; $display("FAIL full_drain_count: got %0d expected 0", count);
        end
        $display("full drain done: count=%0d", count);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 20; i++) begin
            enq_valid = 1'b1;
            enq_instr = 32'h0000_0300 + 32'(i);
            enq_pc    = 32'h0000_3000 + 32'(4 * i);
            deq_ready = (i > 0);
            if (i > 0) begin
                checks += 2;
                if (deq_pc !== 32'h0000_3000 + 32'(4 * (i - 1))) begin
                    errors++; $display("FAIL stream_pc[%0d]: got %h expected %h", i, deq_pc, 32'h3000 + 32'(4 * (i - 1)));
                end
                if (deq_instr !== 32'h0000_0300 + 32'(i - 1)) begin
                    errors++; $display("FAIL stream_instr[%0d]: got %h expected %h", i, deq_instr, 32'h300 + 32'(i - 1));
                end
            end
            step();
            checks++;
            if (count !== 4'd1) begin
                errors++; $display("FAIL stream_count[%0d]: got %0d expected 1", i, count);
            end
            $display("stream i=%0d count=%0d deq_pc=%h", i, count, deq_pc);
        end
        enq_valid = 1'b0;
        deq_ready = 1'b1;
        checks++;
        if (deq_pc !== 32'h0000_3000 + 32'(4 * 19)) begin
            errors++; $display("FAIL stream_last_pc: got %h expected %h", deq_pc, 32'h3000 + 32'(76));
        end
        step();
        deq_ready = 1'b0;
        checks++;
        if (count !== 4'd0) begin
            errors++; $display("FAIL stream_end_count: got %0d expected 0", count);
        end
    endtask

    task automatic test_flush();
        for (int k = 0; k < 5; k++) begin
            push(32'h0000_0400 + 32'(k), 32'h0000_4000 + 32'(4 * k));
        end
        checks++;
        if (count !== 4'd5) begin
            errors++; $display("FAIL flush_pre_count: got %0d expected 5", count);
        end
        flush     = 1'b1;
        enq_valid = 1'b1;
        enq_instr = 32'hDEAD_BEEF;
        enq_pc    = 32'h0000_4444;
        deq_ready = 1'b1;
        step();
        flush     = 1'b0;
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        checks += 2;
        if (count !== 4'd0) begin
            errors++; $display("FAIL flush_count: got %0d expected 0", count);
        end
        if (deq_valid !== 1'b0) begin
            errors++; $display("FAIL flush_deq_valid: got %b expected 0", deq_valid);
        end
        $display("flush: count=%0d deq_valid=%b", count, deq_valid);
        push(32'h00A0_0093, 32'h0000_0040);
        checks += 3;
        if (count !== 4'd1) begin
            errors++; $display("FAIL post_flush_count: got %0d expected 1", count);
        end
        if (deq_instr !== 32'h00A0_0093) begin
            errors++; $display("FAIL post_flush_instr: got %h expected 00a00093", deq_instr);
        end
        if (deq_pc !== 32'h0000_0040) begin
            errors++; $display("FAIL post_flush_pc: got %h expected 00000040", deq_pc);
        end
        $display("post flush: count=%0d deq_instr=%h", count, deq_instr);
        deq_ready = 1'b1;
        step();
        deq_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) begin
            push(32'h0000_0500 + 32'(k), 32'h0000_5000 + 32'(4 * k));
        end
        checks++;
        if (count !== 4'd3) begin
            errors++; $display("FAIL midreset_pre_count: got %0d expected 3", count);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks += 4;
        if (count !== 4'd0) begin
            errors++; $display("FAIL midreset_count: got %0d expected 0", count);
        end
        if (enq_ready !== 1'b1) begin
            errors++; $display("FAIL midreset_enq_ready: got %b expected 1", enq_ready);
        end
        if (deq_valid !== 1'b0) begin
            errors++; $display("FAIL midreset_deq_valid: got %b expected 0", deq_valid);
        end
        if (deq_pc !== 32'h0 || deq_instr !== 32'h0) begin
            errors++; $display("FAIL midreset_deq_data: got %h/%h expected 0/0", deq_pc, deq_instr);
        end
        $display("mid reset: count=%0d", count);
        for (int k = 0; k < 3; k++) begin
            push(32'h0000_0600 + 32'(k), 32'h0000_6000 + 32'(4 * k));
        end
        deq_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checks += 2;
            if (deq_instr !== 32'h0000_0600 + 32'(k)) begin
                errors++; $display("FAIL midreset_order_instr[%0d]: got %h expected %h", k, deq_instr, 32'h600 + 32'(k));
            end
            if (deq_pc !== 32'h0000_6000 + 32'(4 * k)) begin
                errors++; $display("FAIL midreset_order_pc[%0d]: got %h expected %h", k, deq_pc, 32'h6000 + 32'(4 * k));
            end
            step();
            $display("mid reset replay k=%0d count=%0d", k, count);
        end
        deq_ready = 1'b0;
        checks++;
        if (count !== 4'd0) begin
            errors++; $display("FAIL midreset_end_count: got %0d expected 0", count);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        flush     = 1'b0;
        enq_valid = 1'b0;
        enq_instr = 32'h0;
        enq_pc    = 32'h0;
        deq_ready = 1'b0;
        #1;
        test_reset();
        test_fill();
        test_drain();
        test_full_simul();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
